// File: rtl/tmds_decoder.sv
// TMDS symbol decoder with a token-based lock detector.
// Two register stages: symbol classification, then decoded outputs and lock state.
module tmds_decoder #(
  parameter int LOCK_TOKENS = 16,
  parameter int ERR_LIMIT   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [9:0]  i_tmds,
  output logic [7:0]  o_data,
  output logic [1:0]  o_control,
  output logic        o_ve,
  output logic        o_locked,
  output logic        o_sym_err,
  output logic [15:0] o_err_count
);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  localparam logic [8:0] LOCK_TOK_W = 9'(LOCK_TOKENS);
  localparam logic [8:0] ERR_LIM_W  = 9'(ERR_LIMIT);

  genvar gi;

  // Input classification
  logic       is_ctrl;
  logic [1:0] ctrl_pair;
  logic [6:0] trans_bits;
  logic       is_err;

  always_comb begin
    is_ctrl   = 1'b1;
    ctrl_pair = 2'b00;
    case (i_tmds)
      10'b1101010100: ctrl_pair = 2'b00;
      10'b0010101011: ctrl_pair = 2'b01;
      10'b0101010100: ctrl_pair = 2'b10;
      10'b1010101011: ctrl_pair = 2'b11;
      default:        is_ctrl   = 1'b0;
    endcase
  end

  generate
    for (gi = 0; gi < 7; gi++) begin : g_trans
      assign trans_bits[gi] = i_tmds[gi] ^ i_tmds[gi+1];
    end
  endgenerate

  // Valid encodings never toggle more than three times across the low byte
  assign is_err = !is_ctrl && ($countones(trans_bits) > 3);

  // Stage 1: symbol plus classification; s1_valid_reg marks a real symbol after reset
  logic       s1_valid_reg;
  logic [9:0] s1_sym_reg;
  logic       s1_ctrl_reg;
  logic [1:0] s1_pair_reg;
  logic       s1_err_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_sym_reg   <= '0;
      s1_ctrl_reg  <= 1'b0;
      s1_pair_reg  <= 2'b00;
      s1_err_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= 1'b1;
      s1_sym_reg   <= i_tmds;
      s1_ctrl_reg  <= is_ctrl;
      s1_pair_reg  <= ctrl_pair;
      s1_err_reg   <= is_err;
    end
  end

  // Data decode from the stage-1 symbol
  logic [7:0] q_bits;
  logic [7:0] dec_data;

  assign q_bits      = s1_sym_reg[9] ? ~s1_sym_reg[7:0] : s1_sym_reg[7:0];
  assign dec_data[0] = q_bits[0];

  generate
    for (gi = 1; gi < 8; gi++) begin : g_dec
      assign dec_data[gi] = s1_sym_reg[8] ? (q_bits[gi] ^ q_bits[gi-1])
                                          : ~(q_bits[gi] ^ q_bits[gi-1]);
    end
  endgenerate

  // Stage 2: lock FSM and registered outputs
  lock_state_t state_reg;
  logic [7:0]  tok_cnt_reg;
  logic [7:0]  err_run_reg;
  logic        tok_hit;
  logic        err_hit;

  assign tok_hit = ({1'b0, tok_cnt_reg} + 9'd1) == LOCK_TOK_W;
  assign err_hit = ({1'b0, err_run_reg} + 9'd1) == ERR_LIM_W;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= UNLOCKED;
      tok_cnt_reg <= '0;
      err_run_reg <= '0;
      o_data      <= '0;
      o_control   <= 2'b00;
      o_ve        <= 1'b0;
      o_locked    <= 1'b0;
      o_sym_err   <= 1'b0;
      o_err_count <= '0;
    end else begin
      o_data    <= '0;
      o_ve      <= 1'b0;
      o_sym_err <= 1'b0;
      if (s1_valid_reg) begin
        o_sym_err <= s1_err_reg;
        if (s1_ctrl_reg) begin
          o_control <= s1_pair_reg;
        end
        case (state_reg)
          UNLOCKED: begin
            if (s1_ctrl_reg) begin
              if (tok_hit) begin
                state_reg   <= LOCKED;
                o_locked    <= 1'b1;
                tok_cnt_reg <= '0;
              end else begin
                tok_cnt_reg <= tok_cnt_reg + 8'd1;
              end
            end else begin
              tok_cnt_reg <= '0;
            end
          end
          LOCKED: begin
            if (s1_err_reg) begin
              if (o_err_count != 16'hFFFF) begin
                o_err_count <= o_err_count + 16'd1;
              end
              if (err_hit) begin
                state_reg   <= UNLOCKED;
                o_locked    <= 1'b0;
                err_run_reg <= '0;
                tok_cnt_reg <= '0;
              end else begin
                err_run_reg <= err_run_reg + 8'd1;
              end
            end else begin
              err_run_reg <= '0;
              if (!s1_ctrl_reg) begin
                o_ve   <= 1'b1;
                o_data <= dec_data;
              end
            end
          end
          default: state_reg <= UNLOCKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: a reference model queues expected outputs
// per symbol; a monitor pops and compares them two clocks later.
module tb_tmds_decoder;

  localparam int LOCK_TOKENS = 16;
  localparam int ERR_LIMIT   = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [9:0]  i_tmds = '0;
  logic [7:0]  o_data;
  logic [1:0]  o_control;
  logic        o_ve;
  logic        o_locked;
  logic        o_sym_err;
  logic [15:0] o_err_count;

  tmds_decoder #(.LOCK_TOKENS(LOCK_TOKENS), .ERR_LIMIT(ERR_LIMIT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tmds(i_tmds),
    .o_data(o_data), .o_control(o_control), .o_ve(o_ve),
    .o_locked(o_locked), .o_sym_err(o_sym_err), .o_err_count(o_err_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0]  data;
    logic [1:0]  ctrl;
    logic        ve;
    logic        locked;
    logic        sym_err;
    logic [15:0] errc;
  } out_t;

  typedef struct {
    out_t      o;
    logic [9:0] sym;
    int        due;
  } entry_t;

  entry_t sb[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [9:0] tok_table [4];
  bit         m_locked;
  int         m_tokens;
  int         m_err_run;
  int         m_err_total;
  logic [1:0] m_ctrl;

  function automatic int transitions(input logic [9:0] s);
    int n = 0;
    for (int i = 0; i < 7; i++) if (s[i] != s[i+1]) n++;
    return n;
  endfunction

  function automatic int token_index(input logic [9:0] s);
    for (int i = 0; i < 4; i++) if (tok_table[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [7:0] decode_byte(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = (q[i] ^ q[i-1]) ^ ~s[8];
    return d;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_tokens = 0; m_err_run = 0; m_err_total = 0; m_ctrl = 2'b00;
  endtask

  function automatic out_t model_step(input logic [9:0] s);
    out_t o;
    int   ti;
    bit   err;
    ti  = token_index(s);
    err = (ti < 0) && (transitions(s) > 3);
    o = '0;
    o.sym_err = err;
    if (ti >= 0) m_ctrl = 2'(ti);
    if (!m_locked) begin
      if (ti >= 0) begin
        m_tokens++;
        if (m_tokens == LOCK_TOKENS) begin m_locked = 1; m_tokens = 0; end
      end else m_tokens = 0;
    end else if (err) begin
      if (m_err_total < 65535) m_err_total++;
      m_err_run++;
      if (m_err_run == ERR_LIMIT) begin m_locked = 0; m_err_run = 0; m_tokens = 0; end
    end else begin
      m_err_run = 0;
      if (ti < 0) begin o.ve = 1'b1; o.data = decode_byte(s); end
    end
    o.ctrl   = m_ctrl;
    o.locked = m_locked;
    o.errc   = 16'(m_err_total);
    return o;
  endfunction

  task automatic apply(input logic [9:0] s);
    entry_t e;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_tmds  = s;
    e.o   = model_step(s);
    e.sym = s;
    e.due = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic do_reset(input int n);
    entry_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      i_rst_n = 1'b0;
      i_tmds  = 10'($urandom);
      sb.delete();
      model_reset();
      e.o   = '0;
      e.sym = 10'h3FF;
      e.due = cyc + 1;
      sb.push_back(e);
    end
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] s;
    for (int k = 0; k < 200; k++) begin
      s = 10'($urandom);
      if (token_index(s) < 0 && transitions(s) <= 3) return s;
    end
    return 10'b0100000000;
  endfunction

  function automatic logic [9:0] rand_err();
    logic [9:0] s;
    for (int k = 0; k < 200; k++) begin
      s = 10'($urandom);
      if (token_index(s) < 0 && transitions(s) > 3) return s;
    end
    return 10'b0001010101;
  endfunction

  // Monitor
  initial begin
    out_t act;
    entry_t e;
    forever begin
      @(posedge i_clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        act = {o_data, o_control, o_ve, o_locked, o_sym_err, o_err_count};
        vectors++;
        if (act !== e.o) begin
          miscompares++;
          $display("FAIL out_check sym=%b act data=%h ctrl=%b ve=%b lk=%b err=%b cnt=%0d req data=%h ctrl=%b ve=%b lk=%b err=%b cnt=%0d",
                   e.sym, act.data, act.ctrl, act.ve, act.locked, act.sym_err, act.errc,
                   e.o.data, e.o.ctrl, e.o.ve, e.o.locked, e.o.sym_err, e.o.errc);
        end else begin
          $display("vec %0d sym=%b data=%h ctrl=%b ve=%b lk=%b err=%b cnt=%0d ok",
                   vectors, e.sym, act.data, act.ctrl, act.ve, act.locked, act.sym_err, act.errc);
        end
      end
    end
  end

  // Stimulus
  initial begin
    tok_table[0] = 10'b1101010100;
    tok_table[1] = 10'b0010101011;
    tok_table[2] = 10'b0101010100;
    tok_table[3] = 10'b1010101011;
    model_reset();
    do_reset(3);

    for (int k = 0; k < 15; k++) apply(10'b1101010100);
    apply(10'b0010101011);

    apply(10'b0100000000);
    apply(10'b0011111111);
    apply(10'b1011111111);

    apply(10'b0001010101);
    apply(10'b0100000000);

    for (int k = 0; k < 4; k++) apply(10'b0001010101);
    apply(10'b0011111111);

    for (int k = 0; k < 10; k++) apply(tok_table[$urandom_range(0, 3)]);
    apply(rand_data());
    for (int k = 0; k < 16; k++) apply(tok_table[$urandom_range(0, 3)]);

    for (int seg = 0; seg < 5; seg++) begin
      int r;
      for (int k = 0; k < LOCK_TOKENS + 2; k++) apply(tok_table[$urandom_range(0, 3)]);
      for (int k = 0; k < 60; k++) begin
        r = $urandom_range(0, 99);
        if (r < 20)      apply(tok_table[$urandom_range(0, 3)]);
        else if (r < 88) apply(rand_data());
        else             apply(rand_err());
      end
      for (int k = 0; k < ERR_LIMIT; k++) apply(rand_err());
    end

    for (int k = 0; k < LOCK_TOKENS; k++) apply(tok_table[2]);
    for (int k = 0; k < 5; k++) apply(rand_data());
    apply(rand_err());
    apply(rand_data());
    do_reset(1);
    for (int k = 0; k < LOCK_TOKENS - 1; k++) apply(tok_table[1]);
    apply(rand_data());
    for (int k = 0; k < LOCK_TOKENS; k++) apply(tok_table[3]);
    for (int k = 0; k < 4; k++) apply(rand_data());

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge i_clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain act=%0d pending req=0 pending", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 SHALL provide parameter LOCK_TOKENS, default 16: the number of consecutive control tokens needed to declare lock (range 2..255).
REQ-002 SHALL provide parameter ERR_LIMIT, default 4: the number of consecutive symbol errors that drops lock (range 1..255).
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 SHALL have port i_clk, input, 1 bit: the symbol-rate clock; all state updates on the rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port i_tmds, input, 10 bits: one received, word-aligned TMDS symbol per clock.
REQ-007 SHALL have port o_data, output, 8 bits: decoded video byte.
REQ-008 SHALL have port o_control, output, 2 bits: decoded control pair; on the blue channel this is {vs,hs}.
REQ-009 SHALL have port o_ve, output, 1 bit: video data enable; o_data is valid only when o_ve=1.
REQ-010 SHALL have port o_locked, output, 1 bit: lock state indicator.
REQ-011 SHALL have port o_sym_err, output, 1 bit: the current output symbol was invalid.
REQ-012 SHALL have port o_err_count, output, 16 bits: saturating count of symbol errors seen while locked.

Function
REQ-013 SHALL classify a symbol as a control token only on an exact match: 1101010100->00, 0010101011->01, 0101010100->10, 1010101011->11.
REQ-014 For a non-control symbol, SHALL form q[7:0] = i_tmds[7:0], inverted when i_tmds[9]=1.
REQ-015 SHALL decode d[0]=q[0].
REQ-016 For i=1..7, SHALL decode d[i]=q[i]^q[i-1] when i_tmds[8]=1, and d[i]=~(q[i]^q[i-1]) when i_tmds[8]=0.
REQ-017 SHALL flag a symbol error on a non-control symbol whose i_tmds[7:0] has more than 3 transitions between adjacent bits; valid encodings never exceed 3.
REQ-018 SHALL use a two-stage register pipeline: stage 1 registers the symbol and its classification, stage 2 registers the outputs. Fixed latency from i_tmds to outputs is 2 clocks.
REQ-019 SHALL have lock FSM states UNLOCKED and LOCKED, plus an 8-bit token counter and an 8-bit error run counter.
REQ-020 In UNLOCKED, each control token SHALL increment the token counter and any other symbol SHALL clear it; on reaching LOCK_TOKENS the FSM SHALL go to LOCKED on the same edge and clear the counter.
REQ-021 In LOCKED, each errored symbol SHALL increment the error run counter and any valid symbol (control or data) SHALL clear it.
REQ-022 On reaching ERR_LIMIT, the FSM SHALL go to UNLOCKED and clear both counters.
REQ-023 The FSM SHALL evaluate stage-1 classification; o_locked SHALL be aligned with the symbol shown on the outputs.
REQ-024 While locked, for a valid data symbol: o_ve=1, o_data=d, and o_control SHALL hold its last value.
REQ-025 While locked, for a control token: o_ve=0, o_data=0, o_control=decoded pair.
REQ-026 While locked, for an errored symbol: o_ve=0, o_data=0, o_sym_err=1, and o_control SHALL hold.
REQ-027 While unlocked: o_ve=0 and o_data=0; o_control SHALL still update on control tokens; o_sym_err SHALL still report per symbol.
REQ-028 o_err_count SHALL increment only for errored symbols while locked, including the symbol that causes the lock drop, and SHALL saturate at 0xFFFF.
REQ-029 The lock-drop symbol SHALL itself be output with o_locked=0.
REQ-030 The lock-acquire token SHALL be output with o_locked=1.

Reset
REQ-031 While i_rst_n=0 at a rising edge, all outputs SHALL be 0, the FSM SHALL be UNLOCKED, all counters SHALL be 0, and both pipeline stages SHALL be flushed to a non-error, non-video state.
REQ-032 Reset asserted mid-stream SHALL take effect on the next edge, discard in-flight symbols, and require a full LOCK_TOKENS sequence to lock again.

Verification
REQ-033 Reset, then 15 x 1101010100 then 1 x 0010101011 (LOCK_TOKENS=16) -> o_locked rises 2 clocks after the 16th token; o_control=01; o_ve=0.
REQ-034 Once locked, send 0100000000, 0011111111, 1011111111 -> o_data is 0x00, 0xFF, 0xFE on consecutive cycles, o_ve=1, o_sym_err=0.
REQ-035 Once locked, send 0001010101 (7 transitions) once, then valid data -> a single o_sym_err pulse, o_ve=0 for that cycle, o_err_count=1, lock retained.
REQ-036 Once locked, send 4 x 0001010101 -> o_locked falls on the output cycle of the 4th error; o_err_count=4; a later data symbol shows o_ve=0.
REQ-037 Unlocked, send 10 tokens, 1 data symbol, then 16 tokens -> lock only after the final 16; during the first 10 tokens o_control tracks them and o_ve=0.
REQ-038 Locked and streaming, pull i_rst_n low for 1 clock -> all outputs 0 next cycle; o_err_count=0; relock requires 16 tokens.
